fifo_access_arbiter: RTL and testbench
======================================

Name: fifo_access_arbiter

Overview:
Sequences all accesses to the shared strobe-driven byte FIFO used in the FDC data path. It takes three requesters and arbitrates between them: the host/SD side writes, the CPU side reads, and the controller issues flushes. Each granted access is turned into the FIFO's pulse protocol: strobe high for one cycle, then low, and the FIFO commits on the falling edge. The FIFO therefore never sees overlapping read and write strobes, and every requester gets a clean req/ack handshake with an error flag.

Parameters:
WORD_SIZE, 8, data width of the FIFO and both requester data buses

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_req  in  1  write request level, held until wr_ack
wr_data  in  WORD_SIZE  write data, valid while wr_req is high
wr_ack  out  1  one-cycle pulse: write request finished
wr_err  out  1  qualifies wr_ack: write rejected because the FIFO was full
rd_req  in  1  read request level, held until rd_ack
rd_data  out  WORD_SIZE  read data, registered, valid from rd_ack until the next read completes
rd_ack  out  1  one-cycle pulse: read request finished
rd_err  out  1  qualifies rd_ack: read rejected because the FIFO was empty
flush_req  in  1  flush request level, held until flush_ack
flush_ack  out  1  one-cycle pulse: flush done
fifo_d  out  WORD_SIZE  data to the FIFO write port
fifo_q  in  WORD_SIZE  FIFO head word (combinational)
fifo_write  out  1  FIFO write strobe
fifo_read  out  1  FIFO read strobe
fifo_reset  out  1  FIFO clear
fifo_empty  in  1  FIFO empty status
fifo_full  in  1  FIFO full status
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset values: state=IDLE; every ack, err, strobe and busy output 0; rd_data=0; fifo_d=0; last_grant=READ, so the first contended grant goes to write.
- fifo_reset = reset OR reset_d OR (state==FLUSH). reset_d is reset delayed one cycle.
  - Reason: a strobe dropped by reset causes a spurious FIFO commit one cycle later; the extra cycle of fifo_reset clears it.
- States: IDLE, STROBE, RELEASE, DONE, FLUSH.
- IDLE, evaluated every cycle, first match wins:
  - flush_req -> FLUSH.
  - wr_req and rd_req both high -> grant the side opposite last_grant.
  - Only one request high -> grant that side.
- Granted write:
  - fifo_full=1 -> DONE with err=1 and no strobe.
  - Otherwise latch fifo_d<=wr_data and go to STROBE.
- Granted read:
  - fifo_empty=1 -> DONE with err=1 and no strobe.
  - Otherwise latch rd_data<=fifo_q (head word captured before the pointer advances) and go to STROBE.
- The grant updates last_grant, including rejected grants.
- STROBE: the granted strobe (fifo_write or fifo_read) is high for exactly 1 cycle -> RELEASE.
- RELEASE: both strobes low; fifo_d held. The FIFO commits at the end of this cycle -> DONE.
- FLUSH: fifo_reset=1 for exactly 1 cycle -> DONE.
- DONE: pulse the matching ack (wr_ack, rd_ack or flush_ack) for 1 cycle; wr_err/rd_err equal the latched reject flag during the ack, otherwise 0 -> IDLE.
- Latency from request sampled in IDLE to ack:
  - Accepted read/write: 3 cycles (STROBE, RELEASE, DONE ack).
  - Rejected read/write: 1 cycle.
  - Flush: 2 cycles.
- Requesters must drop req in the cycle after ack. A req still high in the IDLE cycle that follows DONE counts as a new request.
- fifo_write and fifo_read are never high in the same cycle, and every strobe is followed by at least one low cycle.
- A flush requested while an access is in flight waits for that access to return to IDLE, then takes priority over pending reads and writes.
- wr_data is sampled only at grant; later changes are ignored.
- rd_data keeps its value through rejected reads.
- Reset in any state: takes effect the next cycle. Strobes go low, the in-flight ack is lost, and fifo_reset is high for the reset cycles plus 1.

Test Plan:
- Empty FIFO, write 0xA5 -> fifo_write high exactly 1 cycle, wr_ack 3 cycles after grant with wr_err=0. Then read -> rd_data=0xA5, rd_err=0, fifo_empty=1 after rd_ack.
- Read while fifo_empty=1 -> rd_ack the cycle after the request with rd_err=1, no fifo_read pulse, rd_data unchanged.
- Fill the FIFO to RAM_SIZE=256, write 0x11 -> wr_ack with wr_err=1, no fifo_write, FIFO contents unchanged.
- wr_req and rd_req held high together over 4 grants, FIFO holding 0x01 -> grant order W,R,W,R; fifo_write and fifo_read never overlap.
- FIFO holding 3 bytes, flush_req and wr_req asserted together -> fifo_reset pulses 1 cycle, flush_ack, then the write is granted; afterwards the FIFO size is 1.
- reset asserted during STROBE of a write -> strobe low the next cycle, fifo_reset high for reset+1 cycles, FIFO empty afterwards, no wr_ack.

Source files
------------

// File: rtl/fifo_access_arbiter_if.sv
// fifo_access_arbiter_if: requester handshakes and FIFO strobe bus of the FIFO access arbiter
interface fifo_access_arbiter_if #(parameter int WORD_SIZE = 8);
  logic wr_req;
  logic [WORD_SIZE-1:0] wr_data;
  logic wr_ack;
  logic wr_err;
  logic rd_req;
  logic [WORD_SIZE-1:0] rd_data;
  logic rd_ack;
  logic rd_err;
  logic flush_req;
  logic flush_ack;
  logic [WORD_SIZE-1:0] fifo_d;
  logic [WORD_SIZE-1:0] fifo_q;
  logic fifo_write;
  logic fifo_read;
  logic fifo_reset;
  logic fifo_empty;
  logic fifo_full;
  logic busy;
  modport slave (
    input wr_req, wr_data, rd_req, flush_req, fifo_q, fifo_empty, fifo_full,
    output wr_ack, wr_err, rd_data, rd_ack, rd_err, flush_ack, fifo_d, fifo_write, fifo_read, fifo_reset, busy
  );
  modport master (
    output wr_req, wr_data, rd_req, flush_req, fifo_q, fifo_empty, fifo_full,
    input wr_ack, wr_err, rd_data, rd_ack, rd_err, flush_ack, fifo_d, fifo_write, fifo_read, fifo_reset, busy
  );
endinterface

// File: rtl/fifo_access_arbiter.sv
// fifo_access_arbiter: arbitrates write/read/flush requesters onto a strobe-driven byte FIFO
module fifo_access_arbiter #(
  parameter int WORD_SIZE = 8
) (
  input logic clk,
  input logic reset,
  fifo_access_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, STROBE, RELEASE, DONE, FLUSH} state_t;
  state_t state;
  logic last_wr;
  logic reset_d;
  logic grant_wr;
  logic reject;
  assign grant_wr = bus.wr_req & (~bus.rd_req | ~last_wr);
  assign reject = grant_wr ? bus.fifo_full : bus.fifo_empty;
  assign bus.fifo_reset = reset | reset_d | (state == FLUSH);
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk) begin
    reset_d <= reset;
    if (reset) begin
      state <= IDLE;
      last_wr <= 1'b0;
      bus.wr_ack <= 1'b0;
      bus.wr_err <= 1'b0;
      bus.rd_ack <= 1'b0;
      bus.rd_err <= 1'b0;
      bus.flush_ack <= 1'b0;
      bus.fifo_write <= 1'b0;
      bus.fifo_read <= 1'b0;
      bus.rd_data <= {WORD_SIZE{1'b0}};
      bus.fifo_d <= {WORD_SIZE{1'b0}};
    end else begin
      case (state)
        IDLE:
          if (bus.flush_req) state <= FLUSH;
          else if (bus.wr_req | bus.rd_req) begin
            last_wr <= grant_wr;
            state <= reject ? DONE : STROBE;
            bus.wr_ack <= grant_wr & reject;
            bus.wr_err <= grant_wr & reject;
            bus.rd_ack <= ~grant_wr & reject;
            bus.rd_err <= ~grant_wr & reject;
            bus.fifo_write <= grant_wr & ~reject;
            bus.fifo_read <= ~grant_wr & ~reject;
            if (grant_wr & ~reject) bus.fifo_d <= bus.wr_data;
            if (~grant_wr & ~reject) bus.rd_data <= bus.fifo_q;
          end
        STROBE: begin
          state <= RELEASE;
          bus.fifo_write <= 1'b0;
          bus.fifo_read <= 1'b0;
        end
        RELEASE: begin
          state <= DONE;
          bus.wr_ack <= last_wr;
          bus.rd_ack <= ~last_wr;
        end
        FLUSH: begin
          state <= DONE;
          bus.flush_ack <= 1'b1;
        end
        default: begin
          state <= IDLE;
          bus.wr_ack <= 1'b0;
          bus.wr_err <= 1'b0;
          bus.rd_ack <= 1'b0;
          bus.rd_err <= 1'b0;
          bus.flush_ack <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_access_arbiter.sv
// tb_fifo_access_arbiter: directed and random transactions checked against a queue-level FIFO reference
module tb_fifo_access_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  fifo_access_arbiter_if #(.WORD_SIZE(8)) bus();
  fifo_access_arbiter #(.WORD_SIZE(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  int errors = 0;
  int checks = 0;
  logic [7:0] mem [256];
  logic [7:0] wp = 8'd0;
  logic [7:0] rp = 8'd0;
  int cnt = 0;
  logic fw_d = 1'b0;
  logic fr_d = 1'b0;
  logic prev_strobe = 1'b0;
  bit mon_on = 1'b0;
  logic [7:0] ref_q [$];
  bit exp_last_w = 1'b0;
  logic [7:0] exp_rd = 8'h00;
  assign bus.fifo_q = mem[rp];
  assign bus.fifo_empty = cnt == 0;
  assign bus.fifo_full = cnt == 256;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(posedge clk) begin
    fw_d <= bus.fifo_write;
    fr_d <= bus.fifo_read;
    if (bus.fifo_reset) begin
      wp <= 8'd0;
      rp <= 8'd0;
      cnt <= 0;
    end else if (fw_d && !bus.fifo_write && cnt < 256) begin
      mem[wp] <= bus.fifo_d;
      wp <= wp + 8'd1;
      cnt <= cnt + 1;
    end else if (fr_d && !bus.fifo_read && cnt > 0) begin
      rp <= rp + 8'd1;
      cnt <= cnt - 1;
    end
  end
  always @(negedge clk) begin
    if (mon_on && !reset) begin
      chk("no_overlap", 32'(bus.fifo_write & bus.fifo_read), 0);
      chk("strobe_gap", 32'((bus.fifo_write | bus.fifo_read) & prev_strobe), 0);
      prev_strobe <= bus.fifo_write | bus.fifo_read;
    end
  end
  task automatic run(input bit w, input bit r, input bit f, input logic [7:0] d);
    bit pw, pr, pf, first, err;
    int kind, lat, n, sw, sr, sf;
    pw = w;
    pr = r;
    pf = f;
    first = 1'b1;
    bus.wr_req = w;
    bus.rd_req = r;
    bus.flush_req = f;
    bus.wr_data = d;
    while (pw || pr || pf) begin
      kind = pf ? 2 : (pw && pr) ? (exp_last_w ? 1 : 0) : pw ? 0 : 1;
      err = kind == 0 ? ref_q.size() == 256 : kind == 1 ? ref_q.size() == 0 : 1'b0;
      lat = kind == 2 ? 2 : err ? 1 : 3;
      n = 0;
      sw = 0;
      sr = 0;
      sf = 0;
      do begin
        @(negedge clk);
        n++;
        sw += int'(bus.fifo_write);
        sr += int'(bus.fifo_read);
        sf += int'(bus.fifo_reset);
        if (bus.fifo_write) bus.wr_data = ~bus.wr_data;
      end while (!(bus.wr_ack || bus.rd_ack || bus.flush_ack) && n < 16);
      chk("ack_latency", n, lat + (first ? 0 : 1));
      chk("ack_kind", {29'd0, bus.flush_ack, bus.rd_ack, bus.wr_ack}, 32'd1 << kind);
      chk("ack_err", {30'd0, bus.rd_err, bus.wr_err}, (kind == 0 && err) ? 1 : (kind == 1 && err) ? 2 : 0);
      chk("strobes", sw + sr * 16 + sf * 256, (kind == 0 && !err) ? 1 : (kind == 1 && !err) ? 16 : kind == 2 ? 256 : 0);
      if (kind == 0) begin
        if (!err) ref_q.push_back(d);
        exp_last_w = 1'b1;
        pw = 1'b0;
        bus.wr_req = 1'b0;
      end else if (kind == 1) begin
        if (!err) exp_rd = ref_q.pop_front();
        exp_last_w = 1'b0;
        pr = 1'b0;
        bus.rd_req = 1'b0;
      end else begin
        ref_q.delete();
        pf = 1'b0;
        bus.flush_req = 1'b0;
      end
      chk("rd_data", bus.rd_data, exp_rd);
      first = 1'b0;
    end
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    chk("fifo_level", cnt, ref_q.size());
    chk("fifo_empty", bus.fifo_empty, ref_q.size() == 0);
  endtask
  initial begin
    bit w, r, f;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    bus.flush_req = 1'b0;
    bus.wr_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_fifo_reset", bus.fifo_reset, 1);
    chk("reset_flags", {bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err, bus.flush_ack, bus.fifo_write, bus.fifo_read, bus.busy}, 0);
    chk("reset_rd_data", bus.rd_data, 0);
    chk("reset_fifo_d", bus.fifo_d, 0);
    reset = 1'b0;
    #1 chk("reset_extend", bus.fifo_reset, 1);
    @(negedge clk);
    chk("reset_released", bus.fifo_reset, 0);
    mon_on = 1'b1;
    run(1, 1, 0, 8'h01);
    run(1, 1, 0, 8'h02);
    run(0, 1, 0, 8'h00);
    run(1, 0, 0, 8'hA5);
    run(0, 1, 0, 8'h00);
    chk("a5_read_back", bus.rd_data, 8'hA5);
    run(1, 0, 0, 8'h31);
    run(1, 0, 0, 8'h32);
    run(1, 0, 0, 8'h33);
    run(1, 0, 1, 8'h44);
    chk("flush_then_write_level", cnt, 1);
    while (ref_q.size() < 256) run(1, 0, 0, 8'($urandom));
    run(1, 0, 0, 8'h11);
    chk("full_level", cnt, 256);
    run(0, 1, 0, 8'h00);
    bus.wr_req = 1'b1;
    bus.wr_data = 8'h5A;
    @(negedge clk);
    chk("rst_strobe_pre", bus.fifo_write, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_strobe_low", bus.fifo_write, 0);
    chk("rst_fifo_reset_a", bus.fifo_reset, 1);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b0;
    bus.wr_req = 1'b0;
    #1 chk("rst_fifo_reset_b", bus.fifo_reset, 1);
    @(negedge clk);
    chk("rst_fifo_reset_c", bus.fifo_reset, 0);
    chk("rst_no_ack", bus.wr_ack, 0);
    chk("rst_fifo_cleared", cnt, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    ref_q.delete();
    exp_last_w = 1'b0;
    exp_rd = 8'h00;
    run(1, 1, 0, 8'h77);
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom);
      r = 1'($urandom);
      f = $urandom_range(0, 7) == 0;
      if (!(w || r || f)) w = 1'b1;
      run(w, r, f, 8'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
